// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel counters plus registered sync/active/start flags.
// Optional VGA_PIPE_DELAY_EN delays hs/vs/active by PIPE_DELAY cycles to match the draw stages.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit HS_ACTIVE  = 1'b0,
   parameter bit VS_ACTIVE  = 1'b0,
   parameter int FC_W       = 8,
   parameter int PIPE_DELAY = 1
) (
   input  logic            vga_clk,
   input  logic            reset,
   output logic [9:0]      DrawX,
   output logic [9:0]      DrawY,
   output logic            hs,
   output logic            vs,
   output logic            active,
   output logic            line_start,
   output logic            frame_start,
   output logic [FC_W-1:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must be at most 1024");
   end
   if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_delay_chk
      $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
   end

`ifdef VGA_PIPE_DELAY_EN
   localparam int STAGES = PIPE_DELAY;
`else
   localparam int STAGES = 0;
`endif

   localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   // {hs, vs, active} at the idle position (H_TOTAL-1, V_TOTAL-1)
   localparam logic [2:0]  FLG_RST = {~HS_ACTIVE, ~VS_ACTIVE, 1'b0};

   logic [9:0] nx, ny;
   logic       hs_n, vs_n, act_n;
   logic [STAGES:0][2:0] flg_pipe;

   // Flags are decoded from the next position so they land with the counters
   always_comb begin
      nx = DrawX + 10'd1;
      ny = DrawY;
      if (DrawX == X_LAST) begin
         nx = '0;
         ny = (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
      end
      hs_n  = ({1'b0, nx} >= HS_BEG && {1'b0, nx} < HS_END) ? HS_ACTIVE : ~HS_ACTIVE;
      vs_n  = ({1'b0, ny} >= VS_BEG && {1'b0, ny} < VS_END) ? VS_ACTIVE : ~VS_ACTIVE;
      act_n = ({1'b0, nx} < H_VIS) && ({1'b0, ny} < V_VIS);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         DrawX       <= X_LAST;
         DrawY       <= Y_LAST;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '1;
      end else begin
         DrawX       <= nx;
         DrawY       <= ny;
         line_start  <= (nx == 10'd0);
         frame_start <= (nx == 10'd0) && (ny == 10'd0);
         if (nx == 10'd0 && ny == 10'd0)
            frame_count <= frame_count + 1'b1;
      end
   end

   // Stage 0 is zero-skew; later stages only exist with the delay feature
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int i = 0; i <= STAGES; i++)
            flg_pipe[i] <= FLG_RST;
      end else begin
         flg_pipe[0] <= {hs_n, vs_n, act_n};
         for (int i = 1; i <= STAGES; i++)
            flg_pipe[i] <= flg_pipe[i-1];
      end
   end

   assign {hs, vs, active} = flg_pipe[STAGES];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for reset/line timing and a tiny-raster
// instance for frame, wrap and random-reset behaviour, both checked against a position model.
module tb_vga_timing_gen;

   logic vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   logic [1:0] rst = 2'b11;
   int tests = 0;
   int fails = 0;

`ifdef VGA_PIPE_DELAY_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int HVI = (g == 0) ? 640 : 8;
      localparam int HFP = (g == 0) ? 16  : 2;
      localparam int HSW = (g == 0) ? 96  : 3;
      localparam int HBP = (g == 0) ? 48  : 3;
      localparam int VVI = (g == 0) ? 480 : 6;
      localparam int VFP = (g == 0) ? 10  : 1;
      localparam int VSW = 2;
      localparam int VBP = (g == 0) ? 33  : 1;
      localparam bit HSA = (g == 0) ? 1'b0 : 1'b1;
      localparam bit VSA = 1'b0;
      localparam int HT = HVI + HFP + HSW + HBP;
      localparam int VT = VVI + VFP + VSW + VBP;
      localparam int FT = HT * VT;

      logic [9:0] DrawX, DrawY;
      logic       hs, vs, active, line_start, frame_start;
      logic [7:0] frame_count;

      vga_timing_gen #(
         .H_VISIBLE(HVI), .H_FRONT(HFP), .H_SYNC(HSW), .H_BACK(HBP),
         .V_VISIBLE(VVI), .V_FRONT(VFP), .V_SYNC(VSW), .V_BACK(VBP),
         .HS_ACTIVE(HSA), .VS_ACTIVE(VSA), .FC_W(8), .PIPE_DELAY(2)
      ) dut (
         .vga_clk(vga_clk), .reset(rst[g]), .DrawX(DrawX), .DrawY(DrawY),
         .hs(hs), .vs(vs), .active(active), .line_start(line_start),
         .frame_start(frame_start), .frame_count(frame_count)
      );

      // Model state: linear position within the frame and a frame counter
      int         pos = 0;
      logic [7:0] fcm = 8'hFF;
      logic [2:0] hist [0:4];
      bit         started = 1'b0;

      function automatic logic [2:0] flags(input int p);
         int x = p % HT;
         int y = p / HT;
         logic h = (x >= HVI + HFP) && (x < HVI + HFP + HSW);
         logic v = (y >= VVI + VFP) && (y < VVI + VFP + VSW);
         return {h ? HSA : ~HSA, v ? VSA : ~VSA, (x < HVI) && (y < VVI)};
      endfunction

      always @(posedge vga_clk) begin : model
         int np;
         if (rst[g]) begin
            np = FT - 1;
            fcm <= 8'hFF;
            for (int k = 0; k < 5; k++) hist[k] <= flags(FT - 1);
         end else begin
            np = (pos + 1) % FT;
            if (np == 0) fcm <= fcm + 8'd1;
            hist[0] <= flags(np);
            for (int k = 1; k < 5; k++) hist[k] <= hist[k-1];
         end
         pos <= np;
         started <= 1'b1;
      end

      always @(negedge vga_clk) begin : compare
         if (started) begin
            chk($sformatf("i%0d.DrawX", g), DrawX, pos % HT);
            chk($sformatf("i%0d.DrawY", g), DrawY, pos / HT);
            chk($sformatf("i%0d.line_start", g), line_start, int'(pos % HT == 0));
            chk($sformatf("i%0d.frame_start", g), frame_start, int'(pos == 0));
            chk($sformatf("i%0d.frame_count", g), frame_count, fcm);
            chk($sformatf("i%0d.hs", g), hs, hist[D][2]);
            chk($sformatf("i%0d.vs", g), vs, hist[D][1]);
            chk($sformatf("i%0d.active", g), active, hist[D][0]);
         end
      end
   end

   task automatic wait_x0(input int x);
      int n = 0;
      while (gi[0].DrawX != 10'(x) && n < 2000) begin
         @(negedge vga_clk);
         n++;
      end
      if (n >= 2000) chk("wait_x0_timeout", gi[0].DrawX, x);
   endtask

   task automatic thread_full;
      int n;
      @(negedge vga_clk);
      chk("rel_x", gi[0].DrawX, 0);
      chk("rel_y", gi[0].DrawY, 0);
      chk("rel_frame_start", gi[0].frame_start, 1);
      chk("rel_line_start", gi[0].line_start, 1);
      chk("rel_fc", gi[0].frame_count, 0);
      chk("rel_active", gi[0].active, (D == 0) ? 1 : 0);
      n = 0;
      do begin
         @(negedge vga_clk);
         n++;
      end while (!gi[0].line_start && n < 1000);
      chk("line_period", n, 800);
      chk("line1_y", gi[0].DrawY, 1);
      wait_x0(639 + D); chk("active_639", gi[0].active, 1);
      wait_x0(640 + D); chk("active_640", gi[0].active, 0);
      wait_x0(655 + D); chk("hs_655", gi[0].hs, 1);
      wait_x0(656 + D); chk("hs_656", gi[0].hs, 0);
      wait_x0(751 + D); chk("hs_751", gi[0].hs, 0);
      wait_x0(752 + D); chk("hs_752", gi[0].hs, 1);
   endtask

   task automatic thread_small;
      int n, hs_hi, vs_lo, frames, guard;
      @(negedge vga_clk);
      chk("s_rel_frame_start", gi[1].frame_start, 1);
      chk("s_rel_fc", gi[1].frame_count, 0);
      n = 0; hs_hi = 0; vs_lo = 0;
      do begin
         if (gi[1].hs) hs_hi++;
         if (!gi[1].vs) vs_lo++;
         @(negedge vga_clk);
         n++;
      end while (!gi[1].frame_start && n < 400);
      chk("s_frame_period", n, 160);
      chk("s_hs_high_cycles", hs_hi, 30);
      chk("s_vs_low_cycles", vs_lo, 32);
      chk("s_fc_frame1", gi[1].frame_count, 1);
      frames = 1; guard = 0;
      while (frames < 257 && guard < 260 * 160) begin
         @(negedge vga_clk);
         guard++;
         if (gi[1].frame_start) begin
            frames++;
            if (frames == 256) chk("s_fc_wrap", gi[1].frame_count, 0);
         end
      end
      chk("s_frames_seen", frames, 257);
      chk("s_fc_257", gi[1].frame_count, 1);
      // One-cycle reset in the middle of a frame
      guard = 0;
      while (!(gi[1].DrawX == 10'd5 && gi[1].DrawY == 10'd4) && guard < 400) begin
         @(negedge vga_clk);
         guard++;
      end
      chk("s_midreset_reached", int'(gi[1].DrawX) * 100 + int'(gi[1].DrawY), 504);
      rst[1] = 1'b1;
      @(negedge vga_clk);
      rst[1] = 1'b0;
      chk("s_mid_rst_x", gi[1].DrawX, 15);
      chk("s_mid_rst_y", gi[1].DrawY, 9);
      chk("s_mid_rst_fc", gi[1].frame_count, 255);
      chk("s_mid_rst_hs", gi[1].hs, 0);
      @(negedge vga_clk);
      chk("s_after_x", gi[1].DrawX, 0);
      chk("s_after_y", gi[1].DrawY, 0);
      chk("s_after_fs", gi[1].frame_start, 1);
      chk("s_after_fc", gi[1].frame_count, 0);
      repeat (20) begin
         repeat ($urandom_range(1, 300)) @(negedge vga_clk);
         rst[1] = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge vga_clk);
         rst[1] = 1'b0;
      end
      repeat (200) @(negedge vga_clk);
   endtask

   initial begin
      rst = 2'b11;
      repeat (3) @(negedge vga_clk);
      chk("rst_x", gi[0].DrawX, 799);
      chk("rst_y", gi[0].DrawY, 524);
      chk("rst_hs", gi[0].hs, 1);
      chk("rst_vs", gi[0].vs, 1);
      chk("rst_active", gi[0].active, 0);
      chk("rst_line_start", gi[0].line_start, 0);
      chk("rst_frame_start", gi[0].frame_start, 0);
      chk("rst_fc", gi[0].frame_count, 255);
      rst = 2'b00;
      fork
         thread_full();
         thread_small();
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
